serializer: RTL and testbench

Parallel-to-serial transmitter, the companion of the deserializer. It accepts WIDTH-bit words over a valid/ready handshake into a one-entry holding register and shifts each word out MSB-first, one bit per clock. Each bit is qualified by a write strobe, so the output drives a deserializer's data/write inputs directly. The holding register lets the next word be accepted while the current word shifts, which gives gap-free back-to-back transmission.

---
 rtl/serializer_if.sv | 22 ++
 rtl/serializer.sv | 118 +++++++++++
 tb/tb_serializer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/serializer_if.sv
// rtl/serializer_if.sv - word handshake and serial-output bundle for the serializer
interface serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid_in;
  logic             ready_out;
  logic             data_out;
  logic             write_out;
  logic             status_out;
  logic             done_out;

  modport master (
    output data_in, data_valid_in,
    input  ready_out, data_out, write_out, status_out, done_out
  );

  modport slave (
    input  data_in, data_valid_in,
    output ready_out, data_out, write_out, status_out, done_out
  );
endinterface

// File: rtl/serializer.sv
// rtl/serializer.sv - MSB-first parallel-to-serial transmitter with a one-word holding register
// Optional trailing even-parity bit enabled by defining SERIALIZER_PARITY_EN.
module serializer #(
  parameter int WIDTH = 8
) (
  input logic          clk_100KHz,
  input logic          reset,
  serializer_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

  state_t             state, state_next;
  logic [WIDTH-1:0]   hold_reg;
  logic               hold_valid;
  logic [WIDTH-1:0]   shift_reg;
  logic [CNT_W-1:0]   bit_cnt;
  logic               done_q;
  logic               done_next;
  logic               load;
  logic               accept;
`ifdef SERIALIZER_PARITY_EN
  logic               par_reg;
`endif

  assign accept = bus.data_valid_in && !hold_valid;

  always_ff @(posedge clk_100KHz) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // load moves the held word into the shifter; it fires from IDLE or at the end of a word
  always_comb begin
    state_next = state;
    load       = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (hold_valid) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt == LAST) begin
`ifdef SERIALIZER_PARITY_EN
          state_next = PARITY;
`else
          done_next = 1'b1;
          if (hold_valid) load = 1'b1;
          else            state_next = IDLE;
`endif
        end
      end
`ifdef SERIALIZER_PARITY_EN
      PARITY: begin
        done_next = 1'b1;
        if (hold_valid) begin
          load       = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_100KHz) begin
    if (reset) begin
      hold_reg   <= '0;
      hold_valid <= 1'b0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      done_q     <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      par_reg    <= 1'b0;
`endif
    end else begin
      if (accept) hold_reg <= bus.data_in;

      if (accept)    hold_valid <= 1'b1;
      else if (load) hold_valid <= 1'b0;

      if (load) begin
        shift_reg <= hold_reg;
        bit_cnt   <= '0;
`ifdef SERIALIZER_PARITY_EN
        par_reg   <= ^hold_reg;
`endif
      end else if (state == SHIFT) begin
        shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
        bit_cnt   <= bit_cnt + 1'b1;
      end

      done_q <= done_next;
    end
  end

  assign bus.ready_out  = !hold_valid;
  assign bus.write_out  = (state != IDLE);
  assign bus.status_out = hold_valid || (state != IDLE);
  assign bus.done_out   = done_q;
`ifdef SERIALIZER_PARITY_EN
  assign bus.data_out   = (state == SHIFT)  ? shift_reg[WIDTH-1] :
                          (state == PARITY) ? par_reg : 1'b0;
`else
  assign bus.data_out   = (state == SHIFT) ? shift_reg[WIDTH-1] : 1'b0;
`endif
endmodule

// File: tb/tb_serializer.sv
// tb/tb_serializer.sv - directed self-checking bench for serializer
// Build with SERIALIZER_PARITY_EN defined to exercise the parity bit.
module tb_serializer;
`ifdef SERIALIZER_PARITY_EN
  localparam int BPW = 9;
`else
  localparam int BPW = 8;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  serializer_if #(.WIDTH(8)) bus ();

  serializer #(.WIDTH(8)) dut (
    .clk_100KHz (clk),
    .reset      (reset),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // bit idx of a word as it appears on the wire; idx 8 is the even-parity bit
  function automatic logic wire_bit(input logic [7:0] w, input int idx);
    if (idx < 8) return w[7-idx];
    return ^w;
  endfunction

  task automatic send_word(input logic [7:0] w, input string tag);
    bus.data_in       = w;
    bus.data_valid_in = 1'b1;
    @(negedge clk);
    check({tag, "_ready_low"}, bus.ready_out, 1'b0);
    check({tag, "_write_idle"}, bus.write_out, 1'b0);
    bus.data_valid_in = 1'b0;
    bus.data_in       = ~w;
    for (int i = 0; i < BPW; i++) begin
      @(negedge clk);
      check({tag, "_write"}, bus.write_out, 1'b1);
      check({tag, "_bit"}, bus.data_out, wire_bit(w, i));
      check({tag, "_no_done"}, bus.done_out, 1'b0);
    end
    @(negedge clk);
    check({tag, "_done"}, bus.done_out, 1'b1);
    check({tag, "_write_end"}, bus.write_out, 1'b0);
    @(negedge clk);
    check({tag, "_done_drop"}, bus.done_out, 1'b0);
    check({tag, "_status_idle"}, bus.status_out, 1'b0);
  endtask

  initial begin
    logic [7:0] w0, w1, cur;
    logic [7:0] bp_words [3];
    int next_w, nbits, done_cnt;
    logic acc_pending;

    bus.data_in       = '0;
    bus.data_valid_in = 1'b0;

    // reset
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", bus.ready_out, 1'b1);
    check("rst_write", bus.write_out, 1'b0);
    check("rst_data", bus.data_out, 1'b0);
    check("rst_status", bus.status_out, 1'b0);
    check("rst_done", bus.done_out, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    send_word(8'hA5, "a5");

    // back-to-back with valid held
    w0 = 8'h3C;
    w1 = 8'hC3;
    bus.data_in       = w0;
    bus.data_valid_in = 1'b1;
    @(negedge clk);
    check("b2b_ready_acc", bus.ready_out, 1'b0);
    bus.data_in = w1;
    for (int i = 0; i < 2 * BPW; i++) begin
      @(negedge clk);
      cur = (i < BPW) ? w0 : w1;
      check("b2b_write", bus.write_out, 1'b1);
      check("b2b_bit", bus.data_out, wire_bit(cur, i % BPW));
      if (i == 0 || i == BPW) check("b2b_ready_hi", bus.ready_out, 1'b1);
      else if (i < BPW)       check("b2b_ready_lo", bus.ready_out, 1'b0);
      if (i == 1) bus.data_valid_in = 1'b0;
      if (i > 0) check("b2b_done", bus.done_out, (i == BPW) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    check("b2b_done2", bus.done_out, 1'b1);
    check("b2b_write_end", bus.write_out, 1'b0);
    @(negedge clk);
    check("b2b_status", bus.status_out, 1'b0);

    // backpressure: three words offered with valid held throughout
    bp_words[0] = 8'h81;
    bp_words[1] = 8'h5A;
    bp_words[2] = 8'hE7;
    next_w   = 0;
    nbits    = 0;
    done_cnt = 0;
    bus.data_in       = bp_words[0];
    bus.data_valid_in = 1'b1;
    acc_pending = bus.ready_out;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (bus.write_out) begin
        if (nbits < 3 * BPW)
          check("bp_bit", bus.data_out, wire_bit(bp_words[nbits / BPW], nbits % BPW));
        else
          check("bp_extra_bit", nbits, 3 * BPW - 1);
        nbits++;
      end
      if (bus.done_out) done_cnt++;
      if (acc_pending) begin
        next_w++;
        if (next_w < 3) bus.data_in = bp_words[next_w];
        else            bus.data_valid_in = 1'b0;
      end
      acc_pending = bus.data_valid_in && bus.ready_out;
    end
    check("bp_bit_count", nbits, 3 * BPW);
    check("bp_accepts", next_w, 3);
    check("bp_done_count", done_cnt, 3);
    check("bp_status", bus.status_out, 1'b0);

    // reset in the middle of a word
    bus.data_in       = 8'hFF;
    bus.data_valid_in = 1'b1;
    @(negedge clk);
    bus.data_valid_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_bit", bus.data_out, 1'b1);
    end
    reset = 1'b1;
    @(negedge clk);
    check("mid_write", bus.write_out, 1'b0);
    check("mid_done", bus.done_out, 1'b0);
    check("mid_status", bus.status_out, 1'b0);
    check("mid_ready", bus.ready_out, 1'b1);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("mid_no_done", bus.done_out, 1'b0);
      check("mid_quiet", bus.write_out, 1'b0);
    end
    send_word(8'h01, "after_rst");

`ifdef SERIALIZER_PARITY_EN
    send_word(8'h07, "par07");
    send_word(8'h03, "par03");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
